// File: rtl/arbitro_unidad_aritmetica.sv
// Round-robin arbiter time-sharing one arithmetic datapath between NCH filter-channel
// controllers, with a registered one-hot grant, a dead settle cycle and a hold watchdog.
module arbitro_unidad_aritmetica #(
  parameter int NCH      = 3,
  parameter int SELW     = 2,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  rel,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            err_timeout,
  output logic [SELW-1:0] err_ch,
  output logic [1:0]      dbg_state
);

  // Handshake: a channel raises req (level) and holds it until done; once gnt[ch] is seen
  // it owns the datapath and ends with a one-cycle rel[ch] on its last step (dropping req
  // also ends it); the watchdog revokes the grant after MAX_HOLD cycles.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] rr_last_q, rr_last_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            err_timeout_q, err_timeout_d;
  logic [SELW-1:0] err_ch_q, err_ch_d;

  logic            found;
  logic [SELW-1:0] win;
  logic            req_win;
  logic            rel_win;

  // Search starts just past the last winner so a re-requesting owner yields to others.
  always_comb begin
    found = 1'b0;
    win   = rr_last_q;
    for (int i = 1; i <= NCH; i++) begin
      int k;
      k = (int'(rr_last_q) + i) % NCH;
      if (!found && req[k]) begin
        found = 1'b1;
        win   = SELW'(k);
      end
    end
  end

  always_comb begin
    req_win = 1'b0;
    rel_win = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_q == SELW'(i)) begin
        req_win = req[i];
        rel_win = rel[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    sel_d         = sel_q;
    rr_last_d     = rr_last_q;
    hold_cnt_d    = hold_cnt_q;
    err_timeout_d = 1'b0;
    err_ch_d      = err_ch_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          sel_d      = win;
          rr_last_d  = win;
          hold_cnt_d = '0;
          for (int i = 0; i < NCH; i++) begin
            gnt_d[i] = (win == SELW'(i));
          end
        end
      end
      GRANT: begin
        hold_cnt_d = hold_cnt_q + CW'(1);
        // A release in the watchdog's final cycle is a clean release, not a timeout.
        if (rel_win || !req_win) begin
          state_d = GAP;
          gnt_d   = '0;
          sel_d   = '0;
        end else if (hold_cnt_q == CW'(MAX_HOLD - 1)) begin
          state_d       = GAP;
          gnt_d         = '0;
          sel_d         = '0;
          err_timeout_d = 1'b1;
          err_ch_d      = sel_q;
        end
      end
      GAP: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      sel_q         <= '0;
      rr_last_q     <= SELW'(NCH - 1);
      hold_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      err_ch_q      <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      sel_q         <= sel_d;
      rr_last_q     <= rr_last_d;
      hold_cnt_q    <= hold_cnt_d;
      err_timeout_q <= err_timeout_d;
      err_ch_q      <= err_ch_d;
    end
  end

  assign gnt         = gnt_q;
  assign sel         = sel_q;
  assign busy        = |gnt_q;
  assign err_timeout = err_timeout_q;
  assign err_ch      = err_ch_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_arbitro_unidad_aritmetica.sv
// Bench for arbitro_unidad_aritmetica: vector table, hand-written corner sequences and
// random traffic checked against a transaction-level model of the arbitration rules.
module tb_arbitro_unidad_aritmetica;
  localparam int NCH      = 3;
  localparam int SELW     = 2;
  localparam int MAX_HOLD = 16;
  localparam int CW       = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  req, rel, gnt;
  logic [SELW-1:0] sel, err_ch;
  logic            busy, err_timeout;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  arbitro_unidad_aritmetica #(.NCH(NCH), .SELW(SELW), .MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel), .gnt(gnt), .sel(sel), .busy(busy),
    .err_timeout(err_timeout), .err_ch(err_ch), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Owner index (-1 = datapath free), cycles it has held, pending dead cycle.
  int m_owner, m_cycles, m_last, m_err_ch;
  bit m_dead, m_err;

  function automatic void model_reset();
    m_owner = -1; m_cycles = 0; m_last = NCH - 1; m_dead = 0; m_err = 0; m_err_ch = 0;
  endfunction

  function automatic void model_step(logic [NCH-1:0] r, logic [NCH-1:0] l);
    m_err = 0;
    if (m_owner >= 0) begin
      m_cycles++;
      if (l[m_owner] || !r[m_owner]) begin
        m_owner = -1; m_dead = 1;
      end else if (m_cycles == MAX_HOLD) begin
        m_err = 1; m_err_ch = m_owner; m_owner = -1; m_dead = 1;
      end
    end else if (m_dead) begin
      m_dead = 0;
    end else begin
      for (int i = 1; i <= NCH; i++) begin
        int c;
        c = (m_last + i) % NCH;
        if (m_owner < 0 && r[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_cycles = 0;
      end
    end
  endfunction

  function automatic logic [NCH-1:0] m_gnt();
    logic [NCH-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] l);
    req = r;
    rel = l;
    model_step(r, l);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    rel   = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  rel;
    logic [NCH-1:0]  gnt;
    logic [SELW-1:0] sel;
    logic            err;
  } vec_t;

  vec_t tbl[17];
  logic [SELW-1:0] exp_q[$];

  initial begin
    tbl[0]  = '{3'b001, 3'b000, 3'b001, 2'd0, 1'b0};
    tbl[1]  = '{3'b001, 3'b000, 3'b001, 2'd0, 1'b0};
    tbl[2]  = '{3'b001, 3'b010, 3'b001, 2'd0, 1'b0};
    tbl[3]  = '{3'b001, 3'b001, 3'b000, 2'd0, 1'b0};
    tbl[4]  = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0};
    tbl[5]  = '{3'b100, 3'b000, 3'b100, 2'd2, 1'b0};
    tbl[6]  = '{3'b100, 3'b000, 3'b100, 2'd2, 1'b0};
    tbl[7]  = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0};
    tbl[8]  = '{3'b011, 3'b000, 3'b000, 2'd0, 1'b0};
    tbl[9]  = '{3'b011, 3'b000, 3'b001, 2'd0, 1'b0};
    tbl[10] = '{3'b011, 3'b001, 3'b000, 2'd0, 1'b0};
    tbl[11] = '{3'b011, 3'b000, 3'b000, 2'd0, 1'b0};
    tbl[12] = '{3'b011, 3'b000, 3'b010, 2'd1, 1'b0};
    tbl[13] = '{3'b011, 3'b010, 3'b000, 2'd0, 1'b0};
    tbl[14] = '{3'b001, 3'b000, 3'b000, 2'd0, 1'b0};
    tbl[15] = '{3'b001, 3'b000, 3'b001, 2'd0, 1'b0};
    tbl[16] = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0};

    // reset state
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_err_ch", err_ch, 0);

    // table: basic grant/release, ignored foreign rel, dropped req, rotation
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].req, tbl[i].rel);
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].sel);
      chk($sformatf("tbl%0d_busy", i), busy, |tbl[i].gnt);
      chk($sformatf("tbl%0d_err", i), err_timeout, tbl[i].err);
    end

    // all three request; each releases 4 cycles after its grant
    do_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd0};
    for (int g = 0; g < 4; g++) begin
      int w;
      logic [SELW-1:0] e;
      w = 0;
      while (!busy && w < 10) begin
        step(3'b111, 3'b000);
        w++;
      end
      chk("rr_grant_seen", busy, 1);
      e = exp_q.pop_front();
      chk($sformatf("rr_order%0d", g), sel, e);
      if (g > 0) chk($sformatf("rr_idle_cycles%0d", g), w, 2);
      for (int k = 0; k < 4; k++) step(3'b111, 3'b000);
      chk($sformatf("rr_hold%0d", g), sel, e);
      step(3'b111, 3'b001 << e);
      chk($sformatf("rr_rel%0d", g), gnt, 0);
    end

    // watchdog: channel 1 never releases
    do_reset();
    begin
      int hi;
      bit done;
      hi = 0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
        step(3'b010, 3'b000);
        if (gnt == 3'b010) hi++;
        else if (hi > 0) begin
          done = 1;
          chk("wd_err_pulse", err_timeout, 1);
          chk("wd_err_ch", err_ch, 1);
          chk("wd_gap_sel", sel, 0);
        end
      end
      chk("wd_done", done, 1);
      chk("wd_len", hi, MAX_HOLD);
      step(3'b010, 3'b000);
      chk("wd_pulse_end", err_timeout, 0);
      chk("wd_err_ch_hold", err_ch, 1);
    end

    // release in the watchdog's last cycle is a normal release
    do_reset();
    for (int i = 0; i < MAX_HOLD; i++) step(3'b010, 3'b000);
    chk("lastrel_still_granted", gnt, 3'b010);
    step(3'b010, 3'b010);
    chk("lastrel_gnt", gnt, 0);
    chk("lastrel_no_err", err_timeout, 0);
    chk("lastrel_err_ch", err_ch, 0);

    // asynchronous reset mid-grant, then channel 0 has priority again
    do_reset();
    step(3'b010, 3'b000);
    step(3'b010, 3'b000);
    chk("amid_gnt", gnt, 3'b010);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(3'b011, 3'b000);
    chk("arst_first_gnt", gnt, 3'b001);
    chk("arst_first_sel", sel, 0);

    // random traffic against the model
    do_reset();
    begin
      logic [NCH-1:0] rq, rl;
      int rel_div;
      rq = '0;
      rel_div = 6;
      for (int n = 0; n < 4000; n++) begin
        if (n % 200 == 0) rel_div = $urandom_range(3, 40);
        for (int c = 0; c < NCH; c++) begin
          if ($urandom_range(0, 9) == 0) rq[c] = ~rq[c];
          rl[c] = ($urandom_range(0, rel_div - 1) == 0);
        end
        step(rq, rl);
        chk("rnd_gnt", gnt, m_gnt());
        chk("rnd_sel", sel, (m_owner >= 0) ? m_owner : 0);
        chk("rnd_busy", busy, m_owner >= 0);
        chk("rnd_err", err_timeout, m_err);
        chk("rnd_err_ch", err_ch, m_err_ch);
      end
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
